// File: rtl/cp0_int_timer_ctrl_pkg.sv
// Shared definitions for the CP0 interrupt/timer controller: register map,
// IP bit layout, FSM encoding and the MTC0/MFC0 port helpers.
package cp0_int_timer_ctrl_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;

   localparam int HW_INT_W  = 6;
   localparam int IP_SW_LSB = 0;
   localparam int IP_HW_LSB = 2;
   localparam int IP_TIMER  = 7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_EXL = 2'd2
   } int_state_e;

   typedef struct packed {
      logic        hit;
      logic [31:0] data;
   } cp0_wr_t;

   // Way1 is the younger instruction, so it overrides way0 on the same register.
   function automatic cp0_wr_t resolve_write(input logic        we,
                                             input logic [4:0]  addr_0,
                                             input logic [31:0] data_0,
                                             input logic [4:0]  addr_1,
                                             input logic [31:0] data_1,
                                             input logic [4:0]  target);
      cp0_wr_t w;
      w.hit  = we & ((addr_0 == target) | (addr_1 == target));
      w.data = (addr_1 == target) ? data_1 : data_0;
      return w;
   endfunction

   function automatic logic [31:0] cp0_read(input logic        re,
                                            input logic [4:0]  addr,
                                            input logic [31:0] count,
                                            input logic [31:0] compare);
      logic [31:0] r;
      r = '0;
      if (re) begin
         if (addr == CP0_COUNT)
            r = count;
         else if (addr == CP0_COMPARE)
            r = compare;
      end
      return r;
   endfunction

endpackage

// File: rtl/cp0_int_timer_ctrl_int_sync.sv
// Multi-flop synchroniser for asynchronous level-sensitive interrupt lines.
module cp0_int_timer_ctrl_int_sync #(
   parameter int WIDTH  = 6,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++)
            sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d;
         for (int i = 1; i < STAGES; i++)
            sync_q[i] <= sync_q[i-1];
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_int_timer_ctrl.sv
// CP0 interrupt and timer controller: Count/Compare timer, IP merge and a
// request/acknowledge FSM that hands one qualified interrupt to CP0 at a time.
module cp0_int_timer_ctrl
   import cp0_int_timer_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int COUNT_DIV   = 2,
   parameter int TIMER_IP    = IP_TIMER
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [HW_INT_W-1:0] int_i,
   input  logic [1:0]          sw_ip,
   input  logic [7:0]          status_im,
   input  logic                status_ie,
   input  logic                status_exl,
   input  logic                wb_cp0_we,
   input  logic [4:0]          wb_cp0_waddr_0,
   input  logic [4:0]          wb_cp0_waddr_1,
   input  logic [31:0]         wb_cp0_wdata_0,
   input  logic [31:0]         wb_cp0_wdata_1,
   input  logic                ex_cp0_re,
   input  logic [4:0]          ex_cp0_raddr_0,
   input  logic [4:0]          ex_cp0_raddr_1,
   output logic [31:0]         ex_cp0_rdata_0,
   output logic [31:0]         ex_cp0_rdata_1,
   input  logic                int_ack,
   output logic [7:0]          cause_ip,
   output logic                timer_int,
   output logic                int_req
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [HW_INT_W-1:0] hw_ip;
   logic [DIV_W-1:0]    div_q;
   logic [31:0]         count_q;
   logic [31:0]         compare_q;
   cp0_wr_t             count_wr;
   cp0_wr_t             compare_wr;
   logic                qualified;
   int_state_e          state_q;
   int_state_e          state_d;
   logic                seen_exl_q;
   logic                seen_exl_d;

   cp0_int_timer_ctrl_int_sync #(
      .WIDTH  (HW_INT_W),
      .STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk (clk),
      .rst (rst),
      .d   (int_i),
      .q   (hw_ip)
   );

   assign count_wr   = resolve_write(wb_cp0_we, wb_cp0_waddr_0, wb_cp0_wdata_0,
                                     wb_cp0_waddr_1, wb_cp0_wdata_1, CP0_COUNT);
   assign compare_wr = resolve_write(wb_cp0_we, wb_cp0_waddr_0, wb_cp0_wdata_0,
                                     wb_cp0_waddr_1, wb_cp0_wdata_1, CP0_COMPARE);

   // Count/Compare timer; an MTC0 always beats the free-running update.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= '0;
         count_q   <= '0;
         compare_q <= '0;
         timer_int <= 1'b0;
      end else begin
         if (count_wr.hit) begin
            count_q <= count_wr.data;
            div_q   <= '0;
         end else if (div_q == DIV_LAST) begin
            count_q <= count_q + 32'd1;
            div_q   <= '0;
         end else begin
            div_q   <= div_q + 1'b1;
         end

         if (compare_wr.hit) begin
            compare_q <= compare_wr.data;
            timer_int <= 1'b0;
         end else if (count_q == compare_q) begin
            timer_int <= 1'b1;
         end
      end
   end

   assign ex_cp0_rdata_0 = cp0_read(ex_cp0_re, ex_cp0_raddr_0, count_q, compare_q);
   assign ex_cp0_rdata_1 = cp0_read(ex_cp0_re, ex_cp0_raddr_1, count_q, compare_q);

   always_comb begin
      cause_ip           = {hw_ip, sw_ip};
      cause_ip[TIMER_IP] = cause_ip[TIMER_IP] | timer_int;
   end

   assign qualified = status_ie & ~status_exl & (|(cause_ip & status_im));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         seen_exl_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seen_exl_q <= seen_exl_d;
      end
   end

   // The handler is finished only once EXL has gone high and come back low.
   always_comb begin
      state_d    = state_q;
      seen_exl_d = seen_exl_q;
      case (state_q)
         ST_IDLE: begin
            if (qualified)
               state_d = ST_REQ;
         end
         ST_REQ: begin
            if (int_ack) begin
               state_d    = ST_WAIT_EXL;
               seen_exl_d = 1'b0;
            end else if (!qualified) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_EXL: begin
            if (status_exl)
               seen_exl_d = 1'b1;
            if (seen_exl_q && !status_exl)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      int_req = (state_q == ST_REQ);
   end

endmodule

// File: tb/tb_cp0_int_timer_ctrl.sv
// Scoreboard bench for cp0_int_timer_ctrl: directed stimulus queues expected
// output values tagged with a cycle, a monitor compares them on the falling edge.
module tb_cp0_int_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  int_i = '0;
  logic [1:0]  sw_ip = '0;
  logic [7:0]  status_im = '0;
  logic        status_ie = 1'b0;
  logic        status_exl = 1'b0;
  logic        wb_cp0_we = 1'b0;
  logic [4:0]  wb_cp0_waddr_0 = '0;
  logic [4:0]  wb_cp0_waddr_1 = '0;
  logic [31:0] wb_cp0_wdata_0 = '0;
  logic [31:0] wb_cp0_wdata_1 = '0;
  logic        ex_cp0_re = 1'b0;
  logic [4:0]  ex_cp0_raddr_0 = '0;
  logic [4:0]  ex_cp0_raddr_1 = '0;
  logic [31:0] ex_cp0_rdata_0;
  logic [31:0] ex_cp0_rdata_1;
  logic        int_ack = 1'b0;
  logic [7:0]  cause_ip;
  logic        timer_int;
  logic        int_req;

  cp0_int_timer_ctrl #(
    .SYNC_STAGES (2),
    .COUNT_DIV   (2),
    .TIMER_IP    (7)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .int_i          (int_i),
    .sw_ip          (sw_ip),
    .status_im      (status_im),
    .status_ie      (status_ie),
    .status_exl     (status_exl),
    .wb_cp0_we      (wb_cp0_we),
    .wb_cp0_waddr_0 (wb_cp0_waddr_0),
    .wb_cp0_waddr_1 (wb_cp0_waddr_1),
    .wb_cp0_wdata_0 (wb_cp0_wdata_0),
    .wb_cp0_wdata_1 (wb_cp0_wdata_1),
    .ex_cp0_re      (ex_cp0_re),
    .ex_cp0_raddr_0 (ex_cp0_raddr_0),
    .ex_cp0_raddr_1 (ex_cp0_raddr_1),
    .ex_cp0_rdata_0 (ex_cp0_rdata_0),
    .ex_cp0_rdata_1 (ex_cp0_rdata_1),
    .int_ack        (int_ack),
    .cause_ip       (cause_ip),
    .timer_int      (timer_int),
    .int_req        (int_req)
  );

  always #5 clk = ~clk;

  localparam int SEL_RD0 = 0, SEL_RD1 = 1, SEL_CAUSE = 2, SEL_TIMER = 3, SEL_REQ = 4;
  localparam int MIN_VEC = 12;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD0:   return ex_cp0_rdata_0;
      SEL_RD1:   return ex_cp0_rdata_1;
      SEL_CAUSE: return {24'd0, cause_ip};
      SEL_TIMER: return {31'd0, timer_int};
      default:   return {31'd0, int_req};
    endcase
  endfunction

  // Monitor: consume every expectation due in the current cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        logic [31:0] got;
        got = observe(sb[i].sel);
        n_vec++;
        if (sb[i].due < cyc || got !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d, due %0d)",
                   sb[i].name, got, sb[i].exp, cyc, sb[i].due);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.due  = cyc;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic rd(input logic re, input logic [4:0] a0, input logic [4:0] a1,
                    input logic [31:0] e0, input logic [31:0] e1, input string name);
    ex_cp0_re      = re;
    ex_cp0_raddr_0 = a0;
    ex_cp0_raddr_1 = a1;
    chk(SEL_RD0, e0, {name, "_rd0"});
    chk(SEL_RD1, e1, {name, "_rd1"});
  endtask

  task automatic mtc0(input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
    wb_cp0_we      = 1'b1;
    wb_cp0_waddr_0 = a0;
    wb_cp0_wdata_0 = d0;
    wb_cp0_waddr_1 = a1;
    wb_cp0_wdata_1 = d1;
    tick(1);
    wb_cp0_we      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    chk(SEL_TIMER, 0, "rst_timer0");
    chk(SEL_REQ, 0, "rst_req0");
    chk(SEL_CAUSE, 0, "rst_cause0");
    rd(1, 9, 11, 0, 0, "rst_regs0");
    rst = 1'b0;

    tick(10);
    rd(1, 9, 9, 5, 5, "count_div");
    tick(1);
    rd(0, 9, 9, 0, 0, "re_off");

    mtc0(9, 32'd0, 11, 32'd3);
    chk(SEL_TIMER, 0, "cmp_wr_clr");
    rd(1, 9, 11, 0, 3, "cnt_cmp_load");
    tick(6);
    chk(SEL_TIMER, 0, "pre_match");
    rd(1, 9, 11, 3, 3, "count3");
    tick(1);
    chk(SEL_TIMER, 1, "timer_set");
    chk(SEL_CAUSE, 32'h80, "cause_timer");
    tick(100);
    chk(SEL_TIMER, 1, "timer_sticky");
    mtc0(11, 32'd50, 0, 32'd0);
    chk(SEL_TIMER, 0, "timer_clr");
    rd(1, 11, 0, 50, 0, "cmp50");

    mtc0(9, 32'h10, 9, 32'h20);
    rd(1, 9, 11, 32'h20, 50, "dual_cnt");
    mtc0(11, 32'd7, 12, 32'hDEAD);
    rd(1, 9, 11, 32'h20, 7, "dual_cmp");
    chk(SEL_TIMER, 0, "no_match");

    status_im = 8'h10;
    status_ie = 1'b1;
    int_i     = 6'b000100;
    tick(1);
    chk(SEL_CAUSE, 0, "sync_1");
    chk(SEL_REQ, 0, "req_idle");
    tick(1);
    chk(SEL_CAUSE, 32'h10, "sync_2");
    chk(SEL_REQ, 0, "req_lat");
    tick(1);
    chk(SEL_REQ, 1, "req_up");
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    status_exl = 1'b1;
    chk(SEL_REQ, 0, "req_acked");
    tick(1);
    status_exl = 1'b0;
    chk(SEL_REQ, 0, "wait_exl");
    tick(1);
    chk(SEL_REQ, 0, "back_idle");
    tick(1);
    chk(SEL_REQ, 1, "re_req");

    status_ie = 1'b0;
    tick(1);
    chk(SEL_REQ, 0, "masked_drop");
    status_ie = 1'b1;
    tick(1);
    chk(SEL_REQ, 1, "unmask_req");
    status_ie = 1'b0;
    int_ack   = 1'b1;
    tick(1);
    status_ie = 1'b1;
    int_ack   = 1'b0;
    chk(SEL_REQ, 0, "ack_wins");
    tick(2);
    chk(SEL_REQ, 0, "wait_needs_exl");
    status_exl = 1'b1;
    tick(1);
    status_exl = 1'b0;
    tick(1);
    chk(SEL_REQ, 0, "exl_done");
    tick(1);
    chk(SEL_REQ, 1, "req_again");

    mtc0(9, 32'hFFFF_FFFF, 11, 32'd0);
    rd(1, 9, 11, 32'hFFFF_FFFF, 0, "cnt_max");
    chk(SEL_TIMER, 0, "pre_wrap");
    tick(2);
    rd(1, 9, 9, 0, 0, "wrap");
    chk(SEL_TIMER, 0, "wrap_lat");
    tick(1);
    chk(SEL_TIMER, 1, "wrap_match");
    chk(SEL_CAUSE, 32'h90, "cause_both");
    chk(SEL_REQ, 1, "req_hold");
    rst = 1'b1;
    tick(1);
    chk(SEL_REQ, 0, "rst_req");
    chk(SEL_TIMER, 0, "rst_timer");
    chk(SEL_CAUSE, 0, "rst_cause");
    rd(1, 9, 11, 0, 0, "rst_regs");
    rst = 1'b0;
    tick(1);
    chk(SEL_CAUSE, 32'h80, "post_rst_timer");
    tick(1);
    chk(SEL_CAUSE, 32'h90, "post_rst_sync");
    chk(SEL_REQ, 0, "post_rst_idle");
    tick(1);
    chk(SEL_REQ, 1, "post_rst_req");
    sw_ip = 2'b10;
    chk(SEL_CAUSE, 32'h92, "sw_merge");

    tick(2);
    while (sb.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: got unchecked expected checked (due %0d)", sb[0].name, sb[0].due);
      sb.delete(0);
    end
    if (n_vec < MIN_VEC) begin
      n_fail++;
      $display("FAIL vector_count: got %0d expected at least %0d", n_vec, MIN_VEC);
    end
    if (n_fail == 0)
      $display("PASS: all vectors matched");
    else
      $display("FAIL summary: got %0d miscompares expected 0", n_fail);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_int_timer_ctrl.md
Name: cp0_int_timer_ctrl

Overview:
Interrupt and timer controller that sequences interrupt delivery into CP0 for the dual-issue core.
- Synchronises the 6 external hardware interrupt lines.
- Owns the CP0 Count (reg 9) and Compare (reg 11) registers and raises the timer interrupt on a match.
- Merges software, hardware and timer pending bits into an IP[7:0] vector for the Cause register.
- Runs a request/acknowledge FSM that presents one qualified interrupt request to the CP0 exception logic, then waits for the handler to complete (EXL cleared).

Parameters:
SYNC_STAGES, 2, flip-flop stages on each external interrupt line (allowed values 2..3)
COUNT_DIV, 2, core clock cycles per Count increment
TIMER_IP, 7, IP bit index ORed with the timer interrupt

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock, synchronous, active-high
int_i  in  6  external hardware interrupts, asynchronous, level, active-high
sw_ip  in  2  Cause.IP[1:0] software interrupt bits from CP0
status_im  in  8  Status.IM[15:8]
status_ie  in  1  Status.IE
status_exl  in  1  Status.EXL
wb_cp0_we  in  1  MTC0 write enable from WB
wb_cp0_waddr_0 / wb_cp0_waddr_1  in  5  write addresses, way0 / way1
wb_cp0_wdata_0 / wb_cp0_wdata_1  in  32  write data, way0 / way1
ex_cp0_re  in  1  MFC0 read enable
ex_cp0_raddr_0 / ex_cp0_raddr_1  in  5  read addresses
ex_cp0_rdata_0 / ex_cp0_rdata_1  out  32  read data; combinational
int_ack  in  1  CP0 has taken the interrupt exception this cycle
cause_ip  out  8  merged pending vector for Cause.IP
timer_int  out  1  sticky timer interrupt flag
int_req  out  1  qualified interrupt request to CP0

Behaviour:
- Reset values: count=0, compare=0, div counter=0, timer_int=0, sync flops=0, FSM=IDLE, int_req=0, cause_ip=0.
- Synchroniser: int_i passes through SYNC_STAGES flops, giving hw_ip[5:0]. A change on int_i appears on cause_ip exactly SYNC_STAGES cycles later.
- cause_ip is combinational: {hw_ip[5:0], sw_ip}, with bit TIMER_IP ORed with timer_int.
- Count:
  - The div counter runs 0..COUNT_DIV-1. Count increments when the div counter equals COUNT_DIV-1.
  - Count wraps 32'hFFFF_FFFF to 0 with no flag.
  - An MTC0 to reg 9 loads wdata and clears the div counter. A write takes precedence over an increment in the same cycle.
- Compare:
  - An MTC0 to reg 11 loads wdata and clears timer_int in that cycle.
  - timer_int is set on the cycle after count==compare. It is sticky until Compare is written.
  - If a Compare write and a match happen in the same cycle, the write wins: timer_int=0. Matching is evaluated against the new values on following cycles.
- Dual write resolution: if both ways address the same register, way1 wins. Writes to any other address are ignored. Nothing is written when wb_cp0_we=0.
- Read: if ex_cp0_re=0, or the address is neither 9 nor 11, rdata=0. Reads return the registered value; there is no write-to-read bypass.
- qualified = status_ie & !status_exl & |(cause_ip & status_im).
- FSM:
  - IDLE: int_req=0. If qualified, go to REQ.
  - REQ: int_req=1.
    - int_ack: go to WAIT_EXL.
    - Else if !qualified (masked, or source dropped): return to IDLE, int_req drops the next cycle.
    - int_ack wins if it coincides with !qualified.
  - WAIT_EXL: int_req=0. Stay until status_exl=1 has been seen and has then returned to 0; then go to IDLE.
    - Implemented with a seen_exl flag, cleared on entry.
  - int_req is registered: it rises 1 cycle after qualified is first seen in IDLE.
  - int_ack while in IDLE or WAIT_EXL is ignored.
- rst asserted mid-operation (any state, mid-divide) returns everything to reset values on the next edge. Pending external lines reappear after SYNC_STAGES cycles.

Decomposition:
- Shared package/header holds:
  - CP0 register addresses: COUNT=9, COMPARE=11, STATUS=12, CAUSE=13.
  - IP bit positions and TIMER_IP.
  - FSM state encodings: IDLE=2'd0, REQ=2'd1, WAIT_EXL=2'd2.
- One natural sub-module: int_sync, a parameterised SYNC_STAGES-deep synchroniser, instantiated once with width 6.

Test Plan:
- Reset then COUNT_DIV=2, 10 cycles idle -> count=5; MFC0 reg 9 returns 32'd5; ex_cp0_re=0 returns 0.
- MTC0 compare=3 at count=0 -> timer_int=1 on the cycle after count==3; cause_ip[7]=1; stays set 100 cycles; MTC0 compare=50 -> timer_int=0 the same edge.
- Same-cycle dual write: way0 count=0x10, way1 count=0x20 -> count=0x20; way1 to reg 12 plus way0 compare=7 -> compare=7, no other register changes.
- int_i[2]=1 with IM=8'h10, IE=1, EXL=0 -> cause_ip[4]=1 after 2 cycles; int_req=1 one cycle later; int_ack -> int_req=0; EXL 1 then 0 -> IDLE; int_req reasserts if int_i is still high.
- In REQ, drive IE=0 before ack -> int_req=0 next cycle, FSM=IDLE; IE=1 again -> re-request.
- count=32'hFFFF_FFFF with compare=0 -> wraps to 0, timer_int=1; assert rst mid-REQ -> int_req=0, count=0, timer_int=0 next cycle.
